yolo_conv_seq: RTL and testbench

Control sequencer that drives one xyolo-class compute unit. It issues pixel and weight buffer read addresses and generates the ld_acc, ld_mp, ld_res and ld_nmac strobes, aligned to buffer read latency and compute pipeline latency. It also flags each final (post-maxpool) result for the write side. It sits between the layer configuration registers and the compute unit, on the producer end of the unit's load-control interface.

---
 rtl/yolo_conv_seq.sv | 208 ++++++++++++++++++++
 tb/tb_yolo_conv_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/yolo_conv_seq.sv
// Control sequencer for one xyolo compute unit: buffer read addressing plus latency-aligned
// ld_acc/ld_mp/ld_res/ld_nmac strobes. Define YOLO_SEQ_PERF_EN to add the `cycles` counter port.

module yolo_conv_seq #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned N_MACS   = 1,
    parameter int unsigned N_MACS_W = ($clog2(N_MACS) == 0) ? 1 : $clog2(N_MACS),
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned LAT      = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [CNT_W-1:0]    n_acc,
    input  logic [CNT_W-1:0]    n_out,
    input  logic [2:0]          mp_win,
    input  logic [ADDR_W-1:0]   pix_start,
    input  logic [CNT_W-1:0]    pix_stride,
    input  logic [ADDR_W-1:0]   w_start,
    output logic [ADDR_W-1:0]   pix_addr,
    output logic [ADDR_W-1:0]   w_addr,
    output logic                rd_en,
    output logic                ld_acc,
    output logic                ld_mp,
    output logic                ld_res,
    output logic [N_MACS_W-1:0] ld_nmac,
    output logic                out_valid,
    output logic                busy,
    output logic                done
`ifdef YOLO_SEQ_PERF_EN
    ,
    output logic [31:0]         cycles
`endif
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]    n_acc_eff, n_acc_q, n_out_q, res_cnt_q;
    logic [CNT_W-1:0]    acc_idx_q, acc_idx_d, out_idx_q, out_idx_d;
    logic [2:0]          mp_win_eff, mp_win_q, win_idx_q;
    logic [ADDR_W-1:0]   stride_q, w_start_q, base_q, base_d;
    logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d, w_addr_q, w_addr_d;
    logic                rd_en_q, rd_en_d, first_q, first_d, last_q, last_d;
    logic [MEM_LAT-1:0]  mfirst_q, mlast_q;
    logic [LAT-1:0]      rlast_q;
    logic [N_MACS_W-1:0] nmac_q;
    logic                out_valid_q;
    logic                accept, issue_end, res_now, final_res, win_end;

    assign n_acc_eff  = (n_acc == '0) ? CNT_W'(1) : n_acc;
    assign mp_win_eff = (mp_win == 3'd0) ? 3'd1 : mp_win;
    assign accept     = (state_q == StIdle) && run;
    assign issue_end  = rd_en_q && last_q && (out_idx_q == n_out_q - CNT_W'(1));
    assign res_now    = rlast_q[LAT-1];
    assign final_res  = res_now && (res_cnt_q == n_out_q - CNT_W'(1));
    assign win_end    = (win_idx_q == mp_win_q - 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (run) state_d = (n_out == '0) ? StDone : StIssue;
            StIssue: if (issue_end) state_d = StDrain;
            StDrain: if (final_res) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy    = (state_q != StIdle);
        done    = (state_q == StDone);
        ld_nmac = busy ? nmac_q : '0;
    end

    // Issue counters: the running base replaces out_idx*pix_stride.
    always_comb begin
        rd_en_d    = 1'b0;
        first_d    = 1'b0;
        last_d     = 1'b0;
        pix_addr_d = '0;
        w_addr_d   = '0;
        acc_idx_d  = acc_idx_q;
        out_idx_d  = out_idx_q;
        base_d     = base_q;
        if (accept && (n_out != '0)) begin
            rd_en_d    = 1'b1;
            first_d    = 1'b1;
            last_d     = (n_acc_eff == CNT_W'(1));
            pix_addr_d = pix_start;
            w_addr_d   = w_start;
            acc_idx_d  = '0;
            out_idx_d  = '0;
            base_d     = pix_start;
        end else if (rd_en_q && !issue_end) begin
            rd_en_d = 1'b1;
            if (last_q) begin
                acc_idx_d  = '0;
                out_idx_d  = out_idx_q + CNT_W'(1);
                base_d     = base_q + stride_q;
                pix_addr_d = base_q + stride_q;
                w_addr_d   = w_start_q;
                first_d    = 1'b1;
                last_d     = (n_acc_q == CNT_W'(1));
            end else begin
                acc_idx_d  = acc_idx_q + CNT_W'(1);
                pix_addr_d = pix_addr_q + ADDR_W'(1);
                w_addr_d   = w_addr_q + ADDR_W'(1);
                last_d     = (acc_idx_q + CNT_W'(2) == n_acc_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_acc_q     <= '0;
            n_out_q     <= '0;
            mp_win_q    <= '0;
            stride_q    <= '0;
            w_start_q   <= '0;
            res_cnt_q   <= '0;
            win_idx_q   <= '0;
            nmac_q      <= '0;
            acc_idx_q   <= '0;
            out_idx_q   <= '0;
            base_q      <= '0;
            pix_addr_q  <= '0;
            w_addr_q    <= '0;
            rd_en_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            mfirst_q    <= '0;
            mlast_q     <= '0;
            rlast_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_idx_q  <= acc_idx_d;
            out_idx_q  <= out_idx_d;
            base_q     <= base_d;
            pix_addr_q <= pix_addr_d;
            w_addr_q   <= w_addr_d;
            rd_en_q    <= rd_en_d;
            first_q    <= first_d;
            last_q     <= last_d;
            if (accept) begin
                n_acc_q   <= n_acc_eff;
                n_out_q   <= n_out;
                mp_win_q  <= mp_win_eff;
                stride_q  <= ADDR_W'(pix_stride);
                w_start_q <= w_start;
                res_cnt_q <= '0;
                win_idx_q <= '0;
                nmac_q    <= '0;
            end else if (res_now) begin
                res_cnt_q <= res_cnt_q + CNT_W'(1);
                win_idx_q <= win_end ? 3'd0 : win_idx_q + 3'd1;
                nmac_q    <= (nmac_q == N_MACS_W'(N_MACS - 1)) ? '0 : nmac_q + N_MACS_W'(1);
            end
            // Buffer latency line, then compute latency line fed by the aligned last flag.
            mfirst_q[0] <= first_q;
            mlast_q[0]  <= last_q;
            for (int i = 1; i < MEM_LAT; i++) begin
                mfirst_q[i] <= mfirst_q[i-1];
                mlast_q[i]  <= mlast_q[i-1];
            end
            rlast_q[0] <= mlast_q[MEM_LAT-1];
            for (int i = 1; i < LAT; i++) begin
                rlast_q[i] <= rlast_q[i-1];
            end
            out_valid_q <= res_now && (win_end || final_res);
        end
    end

    assign pix_addr  = pix_addr_q;
    assign w_addr    = w_addr_q;
    assign rd_en     = rd_en_q;
    assign ld_acc    = mfirst_q[MEM_LAT-1];
    assign ld_res    = res_now;
    assign ld_mp     = res_now && (win_idx_q != 3'd0);
    assign out_valid = out_valid_q;

`ifdef YOLO_SEQ_PERF_EN
    logic [31:0] cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_q <= '0;
        end else if (accept) begin
            cycles_q <= '0;
        end else if (state_q != StIdle) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_yolo_conv_seq.sv
// Scoreboard bench for yolo_conv_seq: a reference timing model queues expected events at run
// time; a negedge monitor pops and compares them as the DUT emits strobes.

module tb_yolo_conv_seq;

    localparam int ADDR_W  = 10;
    localparam int CNT_W   = 12;
    localparam int N_MACS  = 4;
    localparam int MEM_LAT = 1;
    localparam int LAT     = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              run = 1'b0;
    logic [CNT_W-1:0]  n_acc = '0, n_out = '0, pix_stride = '0;
    logic [2:0]        mp_win = '0;
    logic [ADDR_W-1:0] pix_start = '0, w_start = '0;
    logic [ADDR_W-1:0] pix_addr, w_addr;
    logic              rd_en, ld_acc, ld_mp, ld_res, out_valid, busy, done;
    logic [1:0]        ld_nmac;
`ifdef YOLO_SEQ_PERF_EN
    logic [31:0]       cycles;
`endif

    yolo_conv_seq #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .N_MACS (N_MACS),
        .MEM_LAT(MEM_LAT),
        .LAT    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .n_acc     (n_acc),
        .n_out     (n_out),
        .mp_win    (mp_win),
        .pix_start (pix_start),
        .pix_stride(pix_stride),
        .w_start   (w_start),
        .pix_addr  (pix_addr),
        .w_addr    (w_addr),
        .rd_en     (rd_en),
        .ld_acc    (ld_acc),
        .ld_mp     (ld_mp),
        .ld_res    (ld_res),
        .ld_nmac   (ld_nmac),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
`ifdef YOLO_SEQ_PERF_EN
        ,
        .cycles    (cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    int q_rd_cyc[$], q_pix[$], q_w[$];
    int q_acc[$];
    int q_res_cyc[$], q_res_mp[$], q_res_nmac[$];
    int q_ov[$];
    int q_done[$];
    logic done_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pending();
        return q_rd_cyc.size() + q_acc.size() + q_res_cyc.size() + q_ov.size() + q_done.size();
    endfunction

    // Reference timing: events at or after cycle `cutoff` (a reset) are not expected.
    task automatic push_exp(input int c0, input int na_in, input int no, input int mw_in,
                            input int ps, input int st, input int ws, input int cutoff);
        int na, mw, t, r;
        na = (na_in == 0) ? 1 : na_in;
        mw = (mw_in == 0) ? 1 : mw_in;
        if (no == 0 && c0 + 1 < cutoff) q_done.push_back(c0 + 1);
        for (int o = 0; o < no; o++) begin
            for (int a = 0; a < na; a++) begin
                t = c0 + 1 + o * na + a;
                if (t < cutoff) begin
                    q_rd_cyc.push_back(t);
                    q_pix.push_back((ps + o * st + a) % 1024);
                    q_w.push_back((ws + a) % 1024);
                end
            end
            t = c0 + 1 + o * na + MEM_LAT;
            if (t < cutoff) q_acc.push_back(t);
            r = c0 + 1 + o * na + (na - 1) + MEM_LAT + LAT;
            if (r < cutoff) begin
                q_res_cyc.push_back(r);
                q_res_mp.push_back((o % mw) != 0 ? 1 : 0);
                q_res_nmac.push_back(o % N_MACS);
            end
            if (((o % mw) == mw - 1 || o == no - 1) && r + 1 < cutoff) q_ov.push_back(r + 1);
            if (o == no - 1 && r + 1 < cutoff) q_done.push_back(r + 1);
        end
    endtask

    always @(negedge clk) begin
        int e;
        if (!busy) check_eq("idle_zero", {4'b0, pix_addr, w_addr, rd_en, ld_acc, ld_mp, ld_res,
                                          ld_nmac, out_valid, done}, 32'd0);
        if (done_prev) check_eq("busy_after_done", busy, 1'b0);
        done_prev <= done;
        if (rd_en) begin
            if (q_rd_cyc.size() == 0) check_eq("extra_rd_en", 1, 0);
            else begin
                e = q_rd_cyc.pop_front(); check_eq("rd_cycle", cyc, e);
                e = q_pix.pop_front();    check_eq("pix_addr", pix_addr, e);
                e = q_w.pop_front();      check_eq("w_addr", w_addr, e);
            end
        end
        if (ld_acc) begin
            if (q_acc.size() == 0) check_eq("extra_ld_acc", 1, 0);
            else begin e = q_acc.pop_front(); check_eq("ld_acc_cycle", cyc, e); end
        end
        if (ld_mp && !ld_res) check_eq("ld_mp_unqualified", 1, 0);
        if (ld_res) begin
            if (q_res_cyc.size() == 0) check_eq("extra_ld_res", 1, 0);
            else begin
                e = q_res_cyc.pop_front();  check_eq("ld_res_cycle", cyc, e);
                e = q_res_mp.pop_front();   check_eq("ld_mp", ld_mp, e);
                e = q_res_nmac.pop_front(); check_eq("ld_nmac", ld_nmac, e);
            end
        end
        if (out_valid) begin
            if (q_ov.size() == 0) check_eq("extra_out_valid", 1, 0);
            else begin e = q_ov.pop_front(); check_eq("out_valid_cycle", cyc, e); end
        end
        if (done) begin
            check_eq("busy_with_done", busy, 1'b1);
            if (q_done.size() == 0) check_eq("extra_done", 1, 0);
            else begin e = q_done.pop_front(); check_eq("done_cycle", cyc, e); end
        end
    end

    task automatic start_run(input int na, input int no, input int mw, input int ps,
                             input int st, input int ws, input int cutoff);
        int c0;
        @(posedge clk); #1;
        n_acc      = CNT_W'(na);
        n_out      = CNT_W'(no);
        mp_win     = 3'(mw);
        pix_start  = ADDR_W'(ps);
        pix_stride = CNT_W'(st);
        w_start    = ADDR_W'(ws);
        run        = 1'b1;
        c0         = cyc;
        push_exp(c0, na, no, mw, ps, st, ws, c0 + cutoff);
        @(posedge clk); #1;
        run        = 1'b0;
        // Scrambled config must not disturb the latched run.
        n_acc      = CNT_W'($urandom);
        n_out      = CNT_W'($urandom);
        mp_win     = 3'($urandom);
        pix_start  = ADDR_W'($urandom);
        pix_stride = CNT_W'($urandom);
        w_start    = ADDR_W'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && pending() == 0) break;
        end
        check_eq({tag, "_pending"}, pending(), 0);
        check_eq({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {pix_addr, w_addr, rd_en, ld_acc, ld_mp, ld_res, ld_nmac,
                                   out_valid, busy, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        start_run(3, 2, 1, 'h10, 8, 'h40, 1000);
        wait_idle("base");
`ifdef YOLO_SEQ_PERF_EN
        check_eq("perf_cycles", cycles, 32'd14);
`endif

        start_run(3, 4, 2, 'h10, 8, 'h40, 1000);
        repeat (2) @(posedge clk); #1;
        n_out = 12'd7; n_acc = 12'd1; run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        wait_idle("mp_win2");

        start_run(3, 3, 2, 'h10, 8, 'h40, 1000);
        wait_idle("partial_win");

        start_run(0, 1, 1, 'h20, 4, 'h00, 1000);
        wait_idle("n_acc0");

        start_run(2, 0, 1, 'h20, 4, 'h00, 1000);
        wait_idle("n_out0");

        start_run(1, 5, 1, 'h100, 3, 'h3F0, 1000);
        wait_idle("nmac_wrap");

        start_run(2, 3, 0, 'h3FE, 'hFFF, 'h3FF, 1000);
        wait_idle("addr_wrap");

        start_run(3, 2, 1, 'h10, 8, 'h40, 7);
        repeat (6) @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_outputs", {pix_addr, w_addr, rd_en, ld_acc, ld_mp, ld_res, ld_nmac,
                                     out_valid, busy, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("rst_mid_pending", pending(), 0);

        start_run(3, 2, 1, 'h10, 8, 'h40, 1000);
        wait_idle("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
